quad_adder_sched: RTL and testbench

// Lockstep join and sequencing controller for the four-input sample adder.

---
 rtl/quad_adder_sched.sv | 218 +++++++++++++++++++++
 tb/tb_quad_adder_sched.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_adder_sched.sv
// -----------------------------------------------------------------------------
// quad_adder_sched
//
// Lockstep join and sequencing controller for a four-input sample adder.
// One beat is taken from every enabled input stream in the same cycle
// ("fire"). The adder strobes (valid / operand enables / last) are delayed by
// ADD_LAT cycles to line up with the adder output. The output is framed into
// FRAME_LEN-beat packets. Downstream FIFO space is tracked with credits.
// Misaligned tlast and partial-valid stalls are flagged as sticky errors.
//
// Ports
//   CLK, reset        clock, synchronous active-high reset
//   cfg_mask[3:0]     channel enable mask, latched on cfg_start
//   cfg_start         pulse: IDLE -> RUN (ignored when cfg_mask == 0)
//   cfg_stop          pulse: finish the current frame, then go idle
//   cfg_clear         pulse: ERROR -> IDLE, clears the error flags
//   s_tvalid/s_tlast  per-channel stream inputs (bit i = channel i)
//   s_tready          per-channel ready, combinational
//   out_pop           downstream FIFO read strobe, returns one credit
//   add_en/add_valid/add_last   adder strobes, aligned to the adder output
//   busy, state       status (0=IDLE 1=RUN 2=DRAIN 3=ERROR)
//   frame_cnt         completed frames since reset, wraps at 2^16
//   err_timeout, err_misalign   sticky error flags
// -----------------------------------------------------------------------------
module quad_adder_sched #(
    parameter int FRAME_LEN  = 64,
    parameter int ADD_LAT    = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [3:0]  cfg_mask,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic        cfg_clear,
    input  logic [3:0]  s_tvalid,
    input  logic [3:0]  s_tlast,
    output logic [3:0]  s_tready,
    input  logic        out_pop,
    output logic [3:0]  add_en,
    output logic        add_valid,
    output logic        add_last,
    output logic        busy,
    output logic [1:0]  state,
    output logic [15:0] frame_cnt,
    output logic        err_timeout,
    output logic        err_misalign
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    localparam logic [15:0] LAST_BEAT   = 16'(FRAME_LEN - 1);
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [7:0]  CREDIT_MAX  = 8'(FIFO_DEPTH);

    state_t      state_q, state_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] beat_q, beat_d;
    logic [15:0] stall_q, stall_d;
    logic [7:0]  credits_q, credits_d;
    logic [15:0] frame_q, frame_d;
    logic        err_to_q, err_to_d;
    logic        err_mis_q, err_mis_d;

    // Delay pipeline: index ADD_LAT-1 is loaded on fire, index 0 drives the
    // adder strobes.
    logic [ADD_LAT-1:0] pipe_vld_q;
    logic [ADD_LAT-1:0] pipe_last_q;
    logic [3:0]         pipe_en_q [ADD_LAT];

    logic all_valid;
    logic any_valid;
    logic fire;
    logic last_beat;
    logic misalign;
    logic stall_hit;
    logic pipe_busy;

    // Disabled channels count as valid for the join.
    assign all_valid = &(s_tvalid | ~mask_q);
    assign any_valid = |(s_tvalid & mask_q);
    assign fire      = ((state_q == ST_RUN) || (state_q == ST_DRAIN && beat_q != 16'd0))
                       && all_valid && (credits_q != 8'd0);
    assign last_beat = (beat_q == LAST_BEAT);
    assign misalign  = fire && ((s_tlast & mask_q) != (last_beat ? mask_q : 4'h0));
    // Only a partial-valid wait counts as a stall; credit waits do not.
    assign stall_hit = (state_q == ST_RUN) && any_valid && !all_valid
                       && (stall_q == STALL_LIMIT);
    // Beats still travelling toward the output stage. The beat sitting in the
    // output stage leaves this cycle, so the pipeline is empty after this edge
    // when nothing else is in flight.
    assign pipe_busy = |(pipe_vld_q >> 1);

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        beat_d    = beat_q;
        stall_d   = stall_q;
        credits_d = credits_q;
        frame_d   = frame_q;
        err_to_d  = err_to_q;
        err_mis_d = err_mis_q;

        if (fire) begin
            if (last_beat) begin
                beat_d  = 16'd0;
                frame_d = frame_q + 16'd1;
            end else begin
                beat_d = beat_q + 16'd1;
            end
        end

        if (fire && !out_pop) begin
            credits_d = credits_q - 8'd1;
        end else if (out_pop && !fire && credits_q != CREDIT_MAX) begin
            credits_d = credits_q + 8'd1;
        end

        if (state_q == ST_RUN) begin
            if (fire || !any_valid) begin
                stall_d = 16'd0;
            end else if (!all_valid) begin
                stall_d = stall_q + 16'd1;
            end
        end else begin
            stall_d = 16'd0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start && cfg_mask != 4'h0) begin
                    state_d = ST_RUN;
                    mask_d  = cfg_mask;
                    beat_d  = 16'd0;
                end
            end
            ST_RUN, ST_DRAIN: begin
                // Errors win over a same-cycle stop request.
                if (misalign || stall_hit) begin
                    state_d = ST_ERROR;
                    if (misalign) err_mis_d = 1'b1;
                    if (stall_hit) err_to_d = 1'b1;
                end else if (state_q == ST_RUN && cfg_stop) begin
                    state_d = ST_DRAIN;
                end else if (state_q == ST_DRAIN && beat_q == 16'd0 && !pipe_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (cfg_clear) begin
                    state_d   = ST_IDLE;
                    err_to_d  = 1'b0;
                    err_mis_d = 1'b0;
                    beat_d    = 16'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mask_q    <= 4'h0;
            beat_q    <= 16'd0;
            stall_q   <= 16'd0;
            credits_q <= CREDIT_MAX;
            frame_q   <= 16'd0;
            err_to_q  <= 1'b0;
            err_mis_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            beat_q    <= beat_d;
            stall_q   <= stall_d;
            credits_q <= credits_d;
            frame_q   <= frame_d;
            err_to_q  <= err_to_d;
            err_mis_q <= err_mis_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            for (int i = 0; i < ADD_LAT; i++) begin
                pipe_en_q[i] <= 4'h0;
            end
        end else begin
            pipe_vld_q[ADD_LAT-1]  <= fire;
            pipe_last_q[ADD_LAT-1] <= fire & last_beat;
            pipe_en_q[ADD_LAT-1]   <= fire ? mask_q : 4'h0;
            for (int i = 0; i < ADD_LAT - 1; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i+1];
                pipe_last_q[i] <= pipe_last_q[i+1];
                pipe_en_q[i]   <= pipe_en_q[i+1];
            end
        end
    end

    assign s_tready     = {4{fire}} & mask_q;
    assign add_valid    = pipe_vld_q[0];
    assign add_last     = pipe_last_q[0];
    assign add_en       = pipe_en_q[0];
    assign busy         = (state_q != ST_IDLE);
    assign state        = state_q;
    assign frame_cnt    = frame_q;
    assign err_timeout  = err_to_q;
    assign err_misalign = err_mis_q;

endmodule

// File: tb/tb_quad_adder_sched.sv
// -----------------------------------------------------------------------------
// tb_quad_adder_sched
//
// Directed scenarios plus a randomized run for quad_adder_sched
// (FRAME_LEN=4, ADD_LAT=2, FIFO_DEPTH=8, TIMEOUT=10). A behavioural model
// tracks the controller state and keeps a queue of scheduled adder outputs,
// each tagged with the cycle it is due at the adder output.
// -----------------------------------------------------------------------------
module tb_quad_adder_sched;

    localparam int FL = 4;
    localparam int AL = 2;
    localparam int FD = 8;
    localparam int TO = 10;

    logic        CLK = 1'b0;
    logic        reset;
    logic [3:0]  cfg_mask;
    logic        cfg_start, cfg_stop, cfg_clear;
    logic [3:0]  s_tvalid, s_tlast, s_tready;
    logic        out_pop;
    logic [3:0]  add_en;
    logic        add_valid, add_last, busy;
    logic [1:0]  state;
    logic [15:0] frame_cnt;
    logic        err_timeout, err_misalign;

    int checks = 0;
    int passes = 0;

    always #5 CLK = ~CLK;

    quad_adder_sched #(
        .FRAME_LEN (FL),
        .ADD_LAT   (AL),
        .FIFO_DEPTH(FD),
        .TIMEOUT   (TO)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .cfg_mask    (cfg_mask),
        .cfg_start   (cfg_start),
        .cfg_stop    (cfg_stop),
        .cfg_clear   (cfg_clear),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .out_pop     (out_pop),
        .add_en      (add_en),
        .add_valid   (add_valid),
        .add_last    (add_last),
        .busy        (busy),
        .state       (state),
        .frame_cnt   (frame_cnt),
        .err_timeout (err_timeout),
        .err_misalign(err_misalign)
    );

    // ---------------- reference model ----------------
    typedef struct {
        int       due;
        logic [3:0] en;
        logic     last;
    } ent_t;

    ent_t       pq[$];
    int         cyc       = 0;
    int         m_state   = 0;
    logic [3:0] m_mask    = 4'h0;
    int         m_beat    = 0;
    int         m_stall   = 0;
    int         m_credits = FD;
    int         m_frames  = 0;
    bit         m_eto     = 0;
    bit         m_emis    = 0;

    function automatic bit m_fire();
        bit allv;
        allv = &(s_tvalid | ~m_mask);
        return (m_state == 1 || (m_state == 2 && m_beat != 0)) && allv && (m_credits != 0);
    endfunction

    function automatic logic [3:0] exp_ready();
        if (m_fire()) return m_mask;
        return 4'h0;
    endfunction

    function automatic logic exp_av();
        return (pq.size() > 0) && (pq[0].due == cyc);
    endfunction

    function automatic logic [3:0] exp_en();
        if (exp_av()) return pq[0].en;
        return 4'h0;
    endfunction

    function automatic logic exp_last();
        if (exp_av()) return pq[0].last;
        return 1'b0;
    endfunction

    // tlast pattern a well-behaved source would present for the next beat
    function automatic logic [3:0] good_tlast();
        return (m_beat == FL - 1) ? 4'hF : 4'h0;
    endfunction

    task automatic model_edge();
        bit f, lst, mis, to, allv, anyv;
        ent_t e;
        while (pq.size() > 0 && pq[0].due <= cyc) void'(pq.pop_front());
        if (reset) begin
            m_state = 0; m_mask = 4'h0; m_beat = 0; m_stall = 0;
            m_credits = FD; m_frames = 0; m_eto = 0; m_emis = 0;
            pq.delete();
            return;
        end
        allv = &(s_tvalid | ~m_mask);
        anyv = |(s_tvalid & m_mask);
        f    = m_fire();
        lst  = (m_beat == FL - 1);
        mis  = f && ((s_tlast & m_mask) != (lst ? m_mask : 4'h0));
        if (f) begin
            e.due = cyc + AL; e.en = m_mask; e.last = lst;
            pq.push_back(e);
            if (lst) begin
                m_beat = 0;
                m_frames = (m_frames + 1) % 65536;
            end else begin
                m_beat++;
            end
        end
        if (f && !out_pop) m_credits--;
        else if (out_pop && !f && m_credits < FD) m_credits++;
        to = 0;
        if (m_state == 1) begin
            if (f || !anyv) m_stall = 0;
            else if (!allv) m_stall++;
            to = (m_stall == TO);
        end else begin
            m_stall = 0;
        end
        case (m_state)
            0: if (cfg_start && cfg_mask != 4'h0) begin
                   m_state = 1; m_mask = cfg_mask; m_beat = 0;
               end
            1, 2: begin
                if (mis || to) begin
                    m_state = 3;
                    if (mis) m_emis = 1;
                    if (to) m_eto = 1;
                end else if (m_state == 1 && cfg_stop) begin
                    m_state = 2;
                end else if (m_state == 2 && m_beat == 0 && pq.size() == 0) begin
                    m_state = 0;
                end
            end
            3: if (cfg_clear) begin
                   m_state = 0; m_eto = 0; m_emis = 0; m_beat = 0;
               end
            default: ;
        endcase
    endtask

    // Advance one clock: model sees the inputs present before the edge.
    task automatic tick();
        model_edge();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs();
        cfg_mask = 4'h0; cfg_start = 0; cfg_stop = 0; cfg_clear = 0;
        s_tvalid = 4'h0; s_tlast = 4'h0; out_pop = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic do_start(input logic [3:0] m);
        cfg_mask = m; cfg_start = 1; s_tvalid = 4'h0;
        tick();
        cfg_start = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        reset = 1; tick(); tick(); reset = 0;
        #1;
        checks++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passes++;
        checks++; if (add_valid !== 1'b0) $display("FAIL reset_add_valid got=%0b exp=0", add_valid); else passes++;
        checks++; if (add_en !== 4'h0) $display("FAIL reset_add_en got=%h exp=0", add_en); else passes++;
        checks++; if (add_last !== 1'b0) $display("FAIL reset_add_last got=%0b exp=0", add_last); else passes++;
        checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); else passes++;
        checks++; if ({err_timeout, err_misalign} !== 2'b00) $display("FAIL reset_err got=%b exp=00", {err_timeout, err_misalign}); else passes++;
        checks++; if (s_tready !== 4'h0) $display("FAIL reset_tready got=%h exp=0", s_tready); else passes++;
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_credit();
        int fires = 0, pulses = 0;
        int fire_cyc[$];
        do_reset();
        do_start(4'hF);
        s_tvalid = 4'hF;
        for (int i = 0; i < 16; i++) begin
            s_tlast = good_tlast();
            #1;
            checks++; if (s_tready !== exp_ready()) $display("FAIL credit_tready cyc=%0d got=%h exp=%h", cyc, s_tready, exp_ready()); else passes++;
            if (s_tready != 4'h0) begin fires++; fire_cyc.push_back(cyc); end
            tick();
            if (add_valid) begin
                pulses++;
                checks++;
                if (fire_cyc.size() == 0 || cyc - fire_cyc[0] != AL)
                    $display("FAIL credit_latency cyc=%0d got=%0d exp=%0d", cyc, (fire_cyc.size() == 0) ? -1 : cyc - fire_cyc[0], AL);
                else passes++;
                if (fire_cyc.size() > 0) void'(fire_cyc.pop_front());
            end
        end
        #1;
        checks++; if (fires !== 8) $display("FAIL credit_fires got=%0d exp=8", fires); else passes++;
        checks++; if (pulses !== 8) $display("FAIL credit_valids got=%0d exp=8", pulses); else passes++;
        checks++; if (s_tready !== 4'h0) $display("FAIL credit_blocked got=%h exp=0", s_tready); else passes++;
        $display("test_credit fires=%0d valids=%0d", fires, pulses);
    endtask

    task automatic test_frame();
        int fires = 0, nval = 0, nlast = 0;
        do_reset();
        do_start(4'hF);
        out_pop = 1;
        for (int i = 0; i < 14; i++) begin
            s_tvalid = (fires < 8) ? 4'hF : 4'h0;
            s_tlast  = good_tlast();
            #1;
            checks++; if (s_tready !== exp_ready()) $display("FAIL frame_tready cyc=%0d got=%h exp=%h", cyc, s_tready, exp_ready()); else passes++;
            if (s_tready != 4'h0) fires++;
            tick();
            if (add_valid) begin
                checks++;
                if (add_last !== ((nval % FL) == FL - 1))
                    $display("FAIL frame_last beat=%0d got=%0b exp=%0b", nval, add_last, (nval % FL) == FL - 1);
                else passes++;
                if (add_last) nlast++;
                nval++;
            end
        end
        checks++; if (nval !== 8) $display("FAIL frame_valids got=%0d exp=8", nval); else passes++;
        checks++; if (nlast !== 2) $display("FAIL frame_lasts got=%0d exp=2", nlast); else passes++;
        checks++; if (frame_cnt !== 16'd2) $display("FAIL frame_cnt got=%0d exp=2", frame_cnt); else passes++;
        checks++; if ({err_timeout, err_misalign} !== 2'b00) $display("FAIL frame_err got=%b exp=00", {err_timeout, err_misalign}); else passes++;
        $display("test_frame valids=%0d lasts=%0d frames=%0d", nval, nlast, frame_cnt);
    endtask

    task automatic test_mask();
        int nval = 0;
        do_reset();
        do_start(4'b0101);
        out_pop = 1;
        s_tvalid = 4'b0101;
        for (int i = 0; i < 12; i++) begin
            s_tlast = good_tlast() & 4'b0101;
            #1;
            checks++; if (s_tready !== 4'b0101) $display("FAIL mask_tready cyc=%0d got=%b exp=0101", cyc, s_tready); else passes++;
            tick();
            checks++; if (add_valid !== exp_av()) $display("FAIL mask_valid cyc=%0d got=%0b exp=%0b", cyc, add_valid, exp_av()); else passes++;
            if (add_valid) begin
                nval++;
                checks++; if (add_en !== 4'b0101) $display("FAIL mask_en cyc=%0d got=%b exp=0101", cyc, add_en); else passes++;
            end
        end
        $display("test_mask valids=%0d", nval);
    endtask

    task automatic test_timeout();
        do_reset();
        do_start(4'hF);
        s_tvalid = 4'b1011;
        for (int i = 1; i <= TO; i++) begin
            tick();
            if (i == TO - 1) begin
                checks++; if (state !== 2'd1) $display("FAIL timeout_early got=%0d exp=1", state); else passes++;
            end
        end
        checks++; if (state !== 2'd3) $display("FAIL timeout_state got=%0d exp=3", state); else passes++;
        checks++; if (err_timeout !== 1'b1) $display("FAIL timeout_flag got=%0b exp=1", err_timeout); else passes++;
        checks++; if (err_misalign !== 1'b0) $display("FAIL timeout_misflag got=%0b exp=0", err_misalign); else passes++;
        s_tvalid = 4'hF;
        #1;
        checks++; if (s_tready !== 4'h0) $display("FAIL timeout_tready got=%h exp=0", s_tready); else passes++;
        cfg_clear = 1; tick(); cfg_clear = 0;
        checks++; if (state !== 2'd0) $display("FAIL timeout_clear_state got=%0d exp=0", state); else passes++;
        checks++; if ({err_timeout, err_misalign} !== 2'b00) $display("FAIL timeout_clear_err got=%b exp=00", {err_timeout, err_misalign}); else passes++;
        $display("test_timeout state=%0d", state);
    endtask

    task automatic test_misalign();
        do_reset();
        do_start(4'hF);
        out_pop = 1;
        s_tvalid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            s_tlast = (i == 2) ? 4'b0001 : 4'h0;
            #1;
            checks++; if (s_tready !== 4'hF) $display("FAIL mis_tready beat=%0d got=%h exp=f", i, s_tready); else passes++;
            tick();
        end
        checks++; if (state !== 2'd3) $display("FAIL mis_state got=%0d exp=3", state); else passes++;
        checks++; if (err_misalign !== 1'b1) $display("FAIL mis_flag got=%0b exp=1", err_misalign); else passes++;
        s_tlast = 4'h0;
        #1;
        checks++; if (s_tready !== 4'h0) $display("FAIL mis_blocked got=%h exp=0", s_tready); else passes++;
        tick();
        checks++; if (add_valid !== 1'b1) $display("FAIL mis_beat2_valid got=%0b exp=1", add_valid); else passes++;
        checks++; if (add_en !== 4'hF) $display("FAIL mis_beat2_en got=%h exp=f", add_en); else passes++;
        tick();
        checks++; if (add_valid !== 1'b0) $display("FAIL mis_drained got=%0b exp=0", add_valid); else passes++;
        cfg_clear = 1; tick(); cfg_clear = 0;
        checks++; if (state !== 2'd0 || err_misalign !== 1'b0) $display("FAIL mis_clear got=%0d/%0b exp=0/0", state, err_misalign); else passes++;
        $display("test_misalign state=%0d", state);
    endtask

    task automatic test_stop();
        int fires = 0, nval = 0, last_idx = -1, last_cyc = -1, idle_cyc = -1;
        do_reset();
        do_start(4'hF);
        s_tvalid = 4'hF; out_pop = 1;
        s_tlast = good_tlast(); tick();
        if (add_valid) nval++;
        cfg_stop = 1; s_tlast = good_tlast(); tick(); cfg_stop = 0;
        if (add_valid) nval++;
        checks++; if (state !== 2'd2) $display("FAIL stop_drain got=%0d exp=2", state); else passes++;
        for (int i = 0; i < 8; i++) begin
            s_tlast = good_tlast();
            #1;
            if (s_tready != 4'h0) fires++;
            tick();
            if (add_valid) begin
                if (add_last) begin last_idx = nval; last_cyc = cyc; end
                nval++;
            end
            if (state == 2'd0 && idle_cyc < 0) idle_cyc = cyc;
        end
        checks++; if (fires !== 2) $display("FAIL stop_fires got=%0d exp=2", fires); else passes++;
        checks++; if (nval !== 4) $display("FAIL stop_valids got=%0d exp=4", nval); else passes++;
        checks++; if (last_idx !== 3) $display("FAIL stop_last_idx got=%0d exp=3", last_idx); else passes++;
        checks++; if (last_cyc < 0 || idle_cyc !== last_cyc + 1) $display("FAIL stop_idle_cyc got=%0d exp=%0d", idle_cyc, last_cyc + 1); else passes++;
        checks++; if (frame_cnt !== 16'd1) $display("FAIL stop_frames got=%0d exp=1", frame_cnt); else passes++;
        // reset in the middle of a frame, with beats still in the pipeline
        do_start(4'hF);
        s_tlast = good_tlast(); tick();
        s_tlast = good_tlast(); tick();
        reset = 1; tick(); reset = 0;
        #1;
        checks++; if ({add_valid, add_last, add_en} !== 6'd0) $display("FAIL midreset_add got=%b exp=0", {add_valid, add_last, add_en}); else passes++;
        checks++; if ({busy, state} !== 3'd0) $display("FAIL midreset_state got=%b exp=0", {busy, state}); else passes++;
        checks++; if (frame_cnt !== 16'd0) $display("FAIL midreset_frames got=%0d exp=0", frame_cnt); else passes++;
        checks++; if (s_tready !== 4'h0) $display("FAIL midreset_tready got=%h exp=0", s_tready); else passes++;
        $display("test_stop fires=%0d valids=%0d idle_cyc=%0d", fires, nval, idle_cyc);
    endtask

    task automatic test_random();
        int r;
        logic [3:0] v;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            cfg_start = (r < 8);
            cfg_mask  = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            cfg_stop  = (r >= 8 && r < 11);
            cfg_clear = (r >= 11 && r < 18);
            reset     = ($urandom_range(0, 199) == 0);
            out_pop   = ($urandom_range(0, 1) == 1);
            for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 9) < 8);
            if ((i % 100) >= 60 && (i % 100) < 78) v[(i / 100) % 4] = 1'b0;
            s_tvalid = v;
            s_tlast  = good_tlast();
            if ($urandom_range(0, 39) == 0) s_tlast = s_tlast ^ 4'(1 << $urandom_range(0, 3));
            #1;
            checks++; if (s_tready !== exp_ready()) $display("FAIL rnd_tready cyc=%0d got=%h exp=%h", cyc, s_tready, exp_ready()); else passes++;
            tick();
            checks++; if (state !== 2'(m_state)) $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", cyc, state, m_state); else passes++;
            checks++; if (busy !== (m_state != 0)) $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy, m_state != 0); else passes++;
            checks++; if ({add_valid, add_last, add_en} !== {exp_av(), exp_last(), exp_en()})
                $display("FAIL rnd_add cyc=%0d got=%b exp=%b", cyc, {add_valid, add_last, add_en}, {exp_av(), exp_last(), exp_en()}); else passes++;
            checks++; if (frame_cnt !== 16'(m_frames)) $display("FAIL rnd_frames cyc=%0d got=%0d exp=%0d", cyc, frame_cnt, m_frames); else passes++;
            checks++; if ({err_timeout, err_misalign} !== {m_eto, m_emis})
                $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, {err_timeout, err_misalign}, {m_eto, m_emis}); else passes++;
        end
        clear_inputs();
        $display("test_random done frames=%0d", m_frames);
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        test_reset();
        test_credit();
        test_frame();
        test_mask();
        test_timeout();
        test_misalign();
        test_stop();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
